traffic_light_seq_ctrl: RTL and testbench

Parametrised multi-approach traffic light sequencer. It is the successor to the single-approach controller and sits behind uart_rx, consuming its data_out/data_valid byte stream as ASCII commands. It has two modes:
- Auto mode: cycles N approaches through green -> yellow -> all-red on programmable tick counts.
- Manual mode: an operator holds and steps phases over UART, and the safety sequence (yellow then all-red) is always enforced.

---
 rtl/traffic_pkg.sv | 15 +
 rtl/phase_timer.sv | 18 +
 rtl/traffic_light_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_traffic_light_seq_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase type, ASCII command codes and timer sizing for the traffic sequencer
package traffic_pkg;
   typedef enum logic [1:0] {GREEN, YELLOW, ALL_RED} phase_t;
   localparam logic [7:0] CMD_AUTO   = 8'h41;
   localparam logic [7:0] CMD_MANUAL = 8'h4D;
   localparam logic [7:0] CMD_RED    = 8'h52;
   localparam logic [7:0] CMD_NEXT   = 8'h4E;
   localparam logic [7:0] CMD_GREEN  = 8'h47;
   function automatic int tick_width(input int a, input int b, input int c);
      int m;
      m = a > b ? a : b;
      m = m > c ? m : c;
      return m < 2 ? 1 : $clog2(m);
   endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter that parks at zero and flags expiry
module phase_timer #(
   parameter int             W    = 4,
   parameter logic [W-1:0]   INIT = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         zero
);
   logic [W-1:0] count;
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= INIT;
      else if (load) count <= load_value;
      else if (count != '0) count <= count - 1'b1;
   assign zero = count == '0;
endmodule

// File: rtl/traffic_light_seq_ctrl.sv
// traffic_light_seq_ctrl: multi-approach green/yellow/all-red sequencer with auto and UART-driven manual modes
module traffic_light_seq_ctrl
   import traffic_pkg::*;
#(
   parameter int NUM_DIR       = 4,
   parameter int GREEN_TICKS   = 50,
   parameter int YELLOW_TICKS  = 10,
   parameter int ALL_RED_TICKS = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 command,
   input  logic                       command_valid,
   output logic [NUM_DIR-1:0]         red,
   output logic [NUM_DIR-1:0]         yellow,
   output logic [NUM_DIR-1:0]         green,
   output logic [$clog2(NUM_DIR)-1:0] active_dir,
   output logic                       auto_mode,
   output logic                       cmd_error
);
   localparam int TW = tick_width(GREEN_TICKS, YELLOW_TICKS, ALL_RED_TICKS);
   localparam int DW = $clog2(NUM_DIR);
   localparam logic [TW-1:0] G_LD = TW'(GREEN_TICKS - 1);
   localparam logic [TW-1:0] Y_LD = TW'(YELLOW_TICKS - 1);
   localparam logic [TW-1:0] R_LD = TW'(ALL_RED_TICKS - 1);

   phase_t          phase, nphase;
   logic [DW-1:0]   ndir, dir_inc;
   logic [TW-1:0]   load_value;
   logic [NUM_DIR-1:0] onehot;
   logic            pending, npending, nauto, nerr, load, zero, take, noop, fresh;

   phase_timer #(.W(TW), .INIT(R_LD)) u_timer (
      .clk(clk), .rst(rst), .load(load), .load_value(load_value), .zero(zero)
   );

   // the first green after reset goes to approach 0 rather than advancing past it
   assign dir_inc = fresh ? active_dir : active_dir == DW'(NUM_DIR - 1) ? '0 : active_dir + 1'b1;
   assign onehot  = NUM_DIR'(1) << ndir;

   always_comb begin
      nphase     = phase;
      ndir       = active_dir;
      npending   = pending;
      nauto      = auto_mode;
      nerr       = 1'b0;
      load       = 1'b0;
      load_value = G_LD;
      take       = 1'b0;
      noop       = (command == CMD_MANUAL && !auto_mode) || (command == CMD_AUTO && auto_mode);
      if (command_valid && !noop) begin
         if (phase == YELLOW) nerr = 1'b1;
         else if (command == CMD_MANUAL) nauto = 1'b0;
         else if (command == CMD_AUTO) begin
            nauto = 1'b1;
            take  = phase == GREEN;
            load  = phase == GREEN;
         end
         else if (auto_mode) nerr = 1'b1;
         else if ((command == CMD_RED || command == CMD_NEXT) && phase == GREEN) begin
            take       = 1'b1;
            nphase     = YELLOW;
            load       = 1'b1;
            load_value = Y_LD;
            npending   = command == CMD_NEXT;
         end
         else if (command == CMD_NEXT) begin
            take     = 1'b1;
            npending = 1'b1;
         end
         else if (command == CMD_GREEN && phase == ALL_RED && zero) begin
            take     = 1'b1;
            nphase   = GREEN;
            load     = 1'b1;
            npending = 1'b0;
         end
         else nerr = 1'b1;
      end
      // a rejected or mode-only command lets the normal expiry transition proceed
      if (!take) begin
         if (phase == GREEN && auto_mode && zero) begin
            nphase     = YELLOW;
            load       = 1'b1;
            load_value = Y_LD;
         end
         else if (phase == YELLOW && zero) begin
            nphase     = ALL_RED;
            load       = 1'b1;
            load_value = R_LD;
         end
         else if (phase == ALL_RED && zero && (auto_mode || pending)) begin
            nphase   = GREEN;
            ndir     = dir_inc;
            load     = 1'b1;
            npending = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         phase      <= ALL_RED;
         active_dir <= '0;
         auto_mode  <= 1'b1;
         pending    <= 1'b0;
         fresh      <= 1'b1;
         cmd_error  <= 1'b0;
         red        <= '1;
         yellow     <= '0;
         green      <= '0;
      end else begin
         phase      <= nphase;
         active_dir <= ndir;
         auto_mode  <= nauto;
         pending    <= npending;
         fresh      <= fresh && nphase != GREEN;
         cmd_error  <= nerr;
         red        <= nphase == ALL_RED ? '1 : ~onehot;
         yellow     <= nphase == YELLOW ? onehot : '0;
         green      <= nphase == GREEN ? onehot : '0;
      end
endmodule

// File: tb/tb_traffic_light_seq_ctrl.sv
// tb_traffic_light_seq_ctrl: directed checks of auto cycling, manual stepping, rejections and async reset
module tb_traffic_light_seq_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] command = 8'h00;
   logic       command_valid = 1'b0;
   logic [2:0] red, yellow, green;
   logic [1:0] active_dir;
   logic       auto_mode, cmd_error;
   int         tests = 0;
   int         failed = 0;

   traffic_light_seq_ctrl #(.NUM_DIR(3), .GREEN_TICKS(8), .YELLOW_TICKS(3), .ALL_RED_TICKS(2)) dut (
      .clk(clk), .rst(rst), .command(command), .command_valid(command_valid),
      .red(red), .yellow(yellow), .green(green), .active_dir(active_dir),
      .auto_mode(auto_mode), .cmd_error(cmd_error)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ph: 0 = green, 1 = yellow, 2 = all-red
   task automatic chk(input string tag, input int ph, input int dir, input bit au, input bit err);
      logic [2:0]  oh;
      logic [12:0] exp_v, obs;
      oh    = 3'(1 << dir);
      exp_v = {ph == 2 ? 3'b111 : ~oh, ph == 1 ? oh : 3'b000, ph == 0 ? oh : 3'b000, 2'(dir), au, err};
      obs   = {red, yellow, green, active_dir, auto_mode, cmd_error};
      tests++;
      assert (obs === exp_v) else begin
         failed++;
         $error("FAIL %s: got r%b y%b g%b d%0d a%b e%b expected r%b y%b g%b d%0d a%b e%b", tag,
                obs[12:10], obs[9:7], obs[6:4], obs[3:2], obs[1], obs[0],
                exp_v[12:10], exp_v[9:7], exp_v[6:4], exp_v[3:2], exp_v[1], exp_v[0]);
      end
   endtask

   task automatic seg(input string tag, input int ph, input int dir, input bit au, input int n);
      for (int i = 0; i < n; i++) begin
         chk(tag, ph, dir, au, 1'b0);
         step();
      end
   endtask

   task automatic send(input logic [7:0] c);
      command       = c;
      command_valid = 1'b1;
      step();
      command_valid = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset", 2, 0, 1, 0);
      rst = 1'b0;
      seg("boot_red", 2, 0, 1, 2);
      seg("g0", 0, 0, 1, 8);
      seg("y0", 1, 0, 1, 3);
      seg("r0", 2, 0, 1, 2);
      seg("g1", 0, 1, 1, 8);
      seg("y1", 1, 1, 1, 3);
      seg("r1", 2, 1, 1, 2);
      seg("g2", 0, 2, 1, 8);
      seg("y2", 1, 2, 1, 3);
      seg("r2", 2, 2, 1, 2);
      seg("wrap_g0", 0, 0, 1, 3);
      send("M");
      chk("m_green", 0, 0, 0, 0);
      step();
      seg("m_hold", 0, 0, 0, 110);
      send("R");
      chk("r_yellow", 1, 0, 0, 0);
      step();
      seg("m_y0", 1, 0, 0, 2);
      send("G");
      chk("g_early_rej", 2, 0, 0, 1);
      step();
      seg("m_red_hold", 2, 0, 0, 40);
      send("G");
      chk("g_same_dir", 0, 0, 0, 0);
      send("G");
      chk("g_in_green_rej", 0, 0, 0, 1);
      send("X");
      chk("bad_byte_rej", 0, 0, 0, 1);
      step();
      seg("err_clears", 0, 0, 0, 2);
      send("N");
      chk("n_yellow", 1, 0, 0, 0);
      send("N");
      chk("cmd_in_yellow_rej", 1, 0, 0, 1);
      step();
      chk("n_y_last", 1, 0, 0, 0);
      step();
      seg("n_red", 2, 0, 0, 2);
      seg("n_g1", 0, 1, 0, 3);
      send("R");
      chk("r_y1", 1, 1, 0, 0);
      step();
      seg("r_y1b", 1, 1, 0, 2);
      seg("r_hold1", 2, 1, 0, 5);
      send("A");
      chk("a_in_hold", 2, 1, 1, 0);
      step();
      seg("a_g2", 0, 2, 1, 3);
      send("R");
      chk("r_auto_rej", 0, 2, 1, 1);
      step();
      seg("a_g2_tail", 0, 2, 1, 3);
      seg("a_y2", 1, 2, 1, 3);
      seg("a_r2", 2, 2, 1, 2);
      seg("a_g0", 0, 0, 1, 8);
      seg("a_y0", 1, 0, 1, 3);
      seg("a_r0", 2, 0, 1, 2);
      send("M");
      chk("m_g1", 0, 1, 0, 0);
      send("R");
      chk("pre_rst_y1", 1, 1, 0, 0);
      step();
      chk("pre_rst_y1b", 1, 1, 0, 0);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst", 2, 0, 1, 0);
      step();
      chk("rst_held", 2, 0, 1, 0);
      rst = 1'b0;
      seg("post_rst_red", 2, 0, 1, 2);
      seg("post_rst_g0", 0, 0, 1, 3);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
